// File: rtl/mcy_mutant_sweep_ctrl_if.sv
// Result handshake between the mutant sweep controller and whatever logs results.
// Carries one per-mutant verdict per valid/ready transfer.
interface mcy_mutant_sweep_ctrl_if #(
  parameter int MUTSEL_W = 8,
  parameter int BUDGET_W = 16,
  parameter int NUM_CH   = 8
);
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                res_valid_o;
  logic                res_ready_i;
  logic [MUTSEL_W-1:0] res_idx_o;
  logic                res_detected_o;
  logic [BUDGET_W-1:0] res_cycle_o;
  logic [CH_IDX_W-1:0] res_ch_o;

  modport master (
    output res_valid_o, res_idx_o, res_detected_o, res_cycle_o, res_ch_o,
    input  res_ready_i
  );

  modport slave (
    input  res_valid_o, res_idx_o, res_detected_o, res_cycle_o, res_ch_o,
    output res_ready_i
  );
endinterface

// File: rtl/mcy_mutant_sweep_ctrl.sv
// Mutation-coverage sweep: steps mutsel over [first,last], holds the DUT pair in
// reset to settle, then diffs golden vs mutant outputs and reports each verdict.
module mcy_ch_cmp #(
  parameter int CH_WIDTH = 32
) (
  input  logic                en_i,
  input  logic [CH_WIDTH-1:0] golden_i,
  input  logic [CH_WIDTH-1:0] mutant_i,
  output logic                hit_o
);
  assign hit_o = en_i && (golden_i != mutant_i);
endmodule

module mcy_mutant_sweep_ctrl #(
  parameter int NUM_CH        = 8,
  parameter int CH_WIDTH      = 32,
  parameter int MUTSEL_W      = 8,
  parameter int BUDGET_W      = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [MUTSEL_W-1:0]        first_idx_i,
  input  logic [MUTSEL_W-1:0]        last_idx_i,
  input  logic [BUDGET_W-1:0]        budget_i,
  input  logic [NUM_CH-1:0]          cmp_mask_i,
  input  logic                       sample_valid_i,
  input  logic [NUM_CH*CH_WIDTH-1:0] golden_i,
  input  logic [NUM_CH*CH_WIDTH-1:0] mutant_i,
  output logic [MUTSEL_W-1:0]        mutsel_o,
  output logic                       dut_rst_o,
  output logic [MUTSEL_W:0]          detected_cnt_o,
  output logic                       busy_o,
  output logic                       done_o,
  mcy_mutant_sweep_ctrl_if.master    res
);
  localparam int CH_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SET_W    = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_RUN, S_REPORT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [MUTSEL_W-1:0] mutsel_q, mutsel_d;
  logic [MUTSEL_W-1:0] last_q, last_d;
  logic [BUDGET_W-1:0] budget_m1_q, budget_m1_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [BUDGET_W-1:0] run_q, run_d;
  logic                res_valid_q, res_valid_d;
  logic [MUTSEL_W-1:0] res_idx_q, res_idx_d;
  logic                res_det_q, res_det_d;
  logic [BUDGET_W-1:0] res_cycle_q, res_cycle_d;
  logic [CH_IDX_W-1:0] res_ch_q, res_ch_d;
  logic [MUTSEL_W:0]   det_cnt_q, det_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                dut_rst_q, dut_rst_d;

  logic [NUM_CH-1:0]   hit;
  logic [CH_IDX_W-1:0] low_ch;

  // sample_valid_i gates every channel so invalid samples can never register a hit
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    mcy_ch_cmp #(.CH_WIDTH(CH_WIDTH)) u_cmp (
      .en_i     (mask_q[c] & sample_valid_i),
      .golden_i (golden_i[c*CH_WIDTH +: CH_WIDTH]),
      .mutant_i (mutant_i[c*CH_WIDTH +: CH_WIDTH]),
      .hit_o    (hit[c])
    );
  end

  always_comb begin
    low_ch = '0;
    for (int c = NUM_CH - 1; c >= 0; c--)
      if (hit[c]) low_ch = CH_IDX_W'(c);
  end

  always_comb begin
    state_d     = state_q;
    mutsel_d    = mutsel_q;
    last_d      = last_q;
    budget_m1_d = budget_m1_q;
    mask_d      = mask_q;
    settle_d    = settle_q;
    run_d       = run_q;
    res_idx_d   = res_idx_q;
    res_det_d   = res_det_q;
    res_cycle_d = res_cycle_q;
    res_ch_d    = res_ch_q;
    det_cnt_d   = det_cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          last_d      = last_idx_i;
          budget_m1_d = (budget_i == '0) ? '0 : budget_i - 1'b1;
          mask_d      = cmp_mask_i;
          det_cnt_d   = '0;
          if (last_idx_i < first_idx_i) begin
            state_d = S_DONE;
          end else begin
            mutsel_d = first_idx_i;
            settle_d = '0;
            state_d  = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
          run_d   = '0;
          state_d = S_RUN;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_RUN: begin
        if (|hit) begin
          res_idx_d   = mutsel_q;
          res_det_d   = 1'b1;
          res_cycle_d = run_q;
          res_ch_d    = low_ch;
          state_d     = S_REPORT;
        end else if (run_q == budget_m1_q) begin
          res_idx_d   = mutsel_q;
          res_det_d   = 1'b0;
          res_cycle_d = '0;
          res_ch_d    = '0;
          state_d     = S_REPORT;
        end else begin
          run_d = run_q + 1'b1;
        end
      end
      S_REPORT: begin
        if (res.res_ready_i) begin
          if (res_det_q) det_cnt_d = det_cnt_q + 1'b1;
          // equality exit means last=max index never wraps mutsel back to 0
          if (mutsel_q == last_q) begin
            state_d = S_DONE;
          end else begin
            mutsel_d = mutsel_q + 1'b1;
            settle_d = '0;
            state_d  = S_SETUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // status flops track the next state so they line up with state_q
    res_valid_d = (state_d == S_REPORT);
    busy_d      = (state_d == S_SETUP) || (state_d == S_RUN) || (state_d == S_REPORT);
    done_d      = (state_d == S_DONE);
    dut_rst_d   = (state_d != S_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mutsel_q    <= '0;
      last_q      <= '0;
      budget_m1_q <= '0;
      mask_q      <= '0;
      settle_q    <= '0;
      run_q       <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
      res_det_q   <= 1'b0;
      res_cycle_q <= '0;
      res_ch_q    <= '0;
      det_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dut_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      mutsel_q    <= mutsel_d;
      last_q      <= last_d;
      budget_m1_q <= budget_m1_d;
      mask_q      <= mask_d;
      settle_q    <= settle_d;
      run_q       <= run_d;
      res_valid_q <= res_valid_d;
      res_idx_q   <= res_idx_d;
      res_det_q   <= res_det_d;
      res_cycle_q <= res_cycle_d;
      res_ch_q    <= res_ch_d;
      det_cnt_q   <= det_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dut_rst_q   <= dut_rst_d;
    end
  end

  assign mutsel_o           = mutsel_q;
  assign dut_rst_o          = dut_rst_q;
  assign detected_cnt_o     = det_cnt_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign res.res_valid_o    = res_valid_q;
  assign res.res_idx_o      = res_idx_q;
  assign res.res_detected_o = res_det_q;
  assign res.res_cycle_o    = res_cycle_q;
  assign res.res_ch_o       = res_ch_q;
endmodule

// File: tb/tb_mcy_mutant_sweep_ctrl.sv
// Directed bench for the mutant sweep controller: two 8-bit channels, settle of 4.
module tb_mcy_mutant_sweep_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic [7:0]  first_idx_i = '0;
  logic [7:0]  last_idx_i = '0;
  logic [15:0] budget_i = '0;
  logic [1:0]  cmp_mask_i = '0;
  logic        sample_valid_i = 1'b0;
  logic [15:0] golden_i = 16'hA55A;
  logic [15:0] mutant_i = 16'hA55A;
  logic [7:0]  mutsel_o;
  logic        dut_rst_o;
  logic [8:0]  detected_cnt_o;
  logic        busy_o;
  logic        done_o;

  int n_cmp  = 0;
  int n_fail = 0;

  mcy_mutant_sweep_ctrl_if #(.MUTSEL_W(8), .BUDGET_W(16), .NUM_CH(2)) rif ();

  mcy_mutant_sweep_ctrl #(
    .NUM_CH(2), .CH_WIDTH(8), .MUTSEL_W(8), .BUDGET_W(16), .SETTLE_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .first_idx_i(first_idx_i), .last_idx_i(last_idx_i), .budget_i(budget_i),
    .cmp_mask_i(cmp_mask_i), .sample_valid_i(sample_valid_i),
    .golden_i(golden_i), .mutant_i(mutant_i),
    .mutsel_o(mutsel_o), .dut_rst_o(dut_rst_o), .detected_cnt_o(detected_cnt_o),
    .busy_o(busy_o), .done_o(done_o), .res(rif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [7:0] f, input logic [7:0] l,
                             input logic [15:0] b, input logic [1:0] m);
    first_idx_i = f; last_idx_i = l; budget_i = b; cmp_mask_i = m;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_rst_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!dut_rst_o) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic wait_res(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (rif.res_valid_o) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_cmp++;
    if ({mutsel_o, dut_rst_o, busy_o, done_o} !== {8'd0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_ctrl: got mutsel=%0d rst=%b busy=%b done=%b, want 0 1 0 0",
               mutsel_o, dut_rst_o, busy_o, done_o);
    end
    n_cmp++;
    if ({rif.res_valid_o, rif.res_idx_o, rif.res_detected_o, rif.res_cycle_o, rif.res_ch_o, detected_cnt_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got v=%b idx=%0d det=%b cyc=%0d ch=%0d cnt=%0d, want all 0",
               rif.res_valid_o, rif.res_idx_o, rif.res_detected_o, rif.res_cycle_o, rif.res_ch_o, detected_cnt_o);
    end
  endtask

  task automatic test_no_detect_sweep();
    int t, nres, runlen, first_t;
    logic [7:0]  r_idx [3];
    logic        r_det [3];
    logic [15:0] r_cyc [3];
    int          r_run [3];
    golden_i = 16'h3C81; mutant_i = 16'h3C81; sample_valid_i = 1'b1; rif.res_ready_i = 1'b1;
    start_sweep(8'd1, 8'd3, 16'd10, 2'b11);
    t = 0; nres = 0; runlen = 0; first_t = -1;
    while (!done_o && t < 300) begin
      tick(); t++;
      if (!dut_rst_o) runlen++;
      if (rif.res_valid_o) begin
        if (first_t < 0) first_t = t;
        if (nres < 3) begin
          r_idx[nres] = rif.res_idx_o; r_det[nres] = rif.res_detected_o;
          r_cyc[nres] = rif.res_cycle_o; r_run[nres] = runlen;
        end
        runlen = 0; nres++;
      end
    end
    rif.res_ready_i = 1'b0;
    n_cmp++;
    if (!done_o || nres != 3) begin
      n_fail++;
      $display("FAIL nodet_count: got done=%b results=%0d, want done=1 results=3", done_o, nres);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (r_idx[i] !== 8'(i + 1) || r_det[i] !== 1'b0 || r_cyc[i] !== 16'd0 || r_run[i] != 10) begin
          n_fail++;
          $display("FAIL nodet_result%0d: got idx=%0d det=%b cyc=%0d run=%0d, want idx=%0d det=0 cyc=0 run=10",
                   i, r_idx[i], r_det[i], r_cyc[i], r_run[i], i + 1);
        end
      end
    end
    n_cmp++;
    if (first_t != 14) begin
      n_fail++;
      $display("FAIL nodet_latency: got first result at cycle %0d, want 14", first_t);
    end
    n_cmp++;
    if (detected_cnt_o !== 9'd0 || busy_o !== 1'b0 || dut_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL nodet_final: got cnt=%0d busy=%b rst=%b, want 0 0 1", detected_cnt_o, busy_o, dut_rst_o);
    end
  endtask

  task automatic test_early_exit();
    bit ok;
    golden_i = 16'hA55A; mutant_i = 16'hA55A; sample_valid_i = 1'b1; rif.res_ready_i = 1'b0;
    start_sweep(8'd5, 8'd5, 16'd10, 2'b11);
    wait_rst_low(ok);
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL early_run_timeout: got no RUN, want RUN"); end
    tick(); tick();
    mutant_i = 16'hA55A ^ 16'h0100;
    tick();
    mutant_i = golden_i;
    n_cmp++;
    if (rif.res_valid_o !== 1'b1 || rif.res_detected_o !== 1'b1 || rif.res_cycle_o !== 16'd2 ||
        rif.res_ch_o !== 1'b1 || rif.res_idx_o !== 8'd5 || dut_rst_o !== 1'b1) begin
      n_fail++;
      $display("FAIL early_result: got v=%b det=%b cyc=%0d ch=%0d idx=%0d rst=%b, want 1 1 2 1 5 1",
               rif.res_valid_o, rif.res_detected_o, rif.res_cycle_o, rif.res_ch_o, rif.res_idx_o, dut_rst_o);
    end
    rif.res_ready_i = 1'b1; tick(); rif.res_ready_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || detected_cnt_o !== 9'd1 || rif.res_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL early_done: got done=%b busy=%b cnt=%0d v=%b, want 1 0 1 0",
               done_o, busy_o, detected_cnt_o, rif.res_valid_o);
    end
  endtask

  task automatic test_mask_and_valid();
    bit ok;
    int runlen;
    golden_i = 16'hA55A; mutant_i = 16'hA55A; sample_valid_i = 1'b1; rif.res_ready_i = 1'b0;
    start_sweep(8'd7, 8'd7, 16'd6, 2'b10);
    wait_rst_low(ok);
    runlen = 0;
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin mutant_i = 16'hA55A ^ 16'h0001; sample_valid_i = 1'b1; end
      else            begin mutant_i = 16'hA55A ^ 16'h0100; sample_valid_i = 1'b0; end
      tick(); runlen++;
      if (rif.res_valid_o) break;
    end
    mutant_i = golden_i; sample_valid_i = 1'b1;
    n_cmp++;
    if (!ok || rif.res_valid_o !== 1'b1 || runlen != 6) begin
      n_fail++;
      $display("FAIL masked_budget: got run=%b v=%b runlen=%0d, want 1 1 6", ok, rif.res_valid_o, runlen);
    end
    n_cmp++;
    if (rif.res_detected_o !== 1'b0 || rif.res_cycle_o !== 16'd0 || rif.res_ch_o !== 1'b0 || rif.res_idx_o !== 8'd7) begin
      n_fail++;
      $display("FAIL masked_result: got det=%b cyc=%0d ch=%0d idx=%0d, want 0 0 0 7",
               rif.res_detected_o, rif.res_cycle_o, rif.res_ch_o, rif.res_idx_o);
    end
    rif.res_ready_i = 1'b1; tick(); rif.res_ready_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || detected_cnt_o !== 9'd0) begin
      n_fail++;
      $display("FAIL masked_done: got done=%b cnt=%0d, want 1 0", done_o, detected_cnt_o);
    end
  endtask

  task automatic test_last_cycle();
    bit ok;
    golden_i = 16'hA55A; mutant_i = 16'hA55A; sample_valid_i = 1'b1; rif.res_ready_i = 1'b0;
    start_sweep(8'd9, 8'd9, 16'd3, 2'b11);
    wait_rst_low(ok);
    tick(); tick();
    mutant_i = 16'hA55A ^ 16'h0101;
    tick();
    mutant_i = golden_i;
    n_cmp++;
    if (!ok || rif.res_valid_o !== 1'b1 || rif.res_detected_o !== 1'b1 ||
        rif.res_cycle_o !== 16'd2 || rif.res_ch_o !== 1'b0) begin
      n_fail++;
      $display("FAIL last_cycle_hit: got v=%b det=%b cyc=%0d ch=%0d, want 1 1 2 0",
               rif.res_valid_o, rif.res_detected_o, rif.res_cycle_o, rif.res_ch_o);
    end
    rif.res_ready_i = 1'b1; tick(); rif.res_ready_i = 1'b0;
    start_sweep(8'd11, 8'd11, 16'd0, 2'b11);
    wait_rst_low(ok);
    tick();
    n_cmp++;
    if (!ok || rif.res_valid_o !== 1'b1 || rif.res_detected_o !== 1'b0 || rif.res_idx_o !== 8'd11) begin
      n_fail++;
      $display("FAIL zero_budget: got v=%b det=%b idx=%0d, want 1 0 11",
               rif.res_valid_o, rif.res_detected_o, rif.res_idx_o);
    end
    rif.res_ready_i = 1'b1; tick(); rif.res_ready_i = 1'b0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int stalls_bad;
    golden_i = 16'hA55A; mutant_i = 16'hA55A ^ 16'h0200; sample_valid_i = 1'b1; rif.res_ready_i = 1'b0;
    start_sweep(8'd20, 8'd21, 16'd4, 2'b11);
    wait_res(ok);
    stalls_bad = 0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (!ok || rif.res_valid_o !== 1'b1 || rif.res_idx_o !== 8'd20 || rif.res_detected_o !== 1'b1 ||
          rif.res_cycle_o !== 16'd0 || rif.res_ch_o !== 1'b1 || mutsel_o !== 8'd20 ||
          busy_o !== 1'b1 || dut_rst_o !== 1'b1) begin
        n_fail++; stalls_bad++;
        $display("FAIL stall_hold%0d: got v=%b idx=%0d det=%b cyc=%0d ch=%0d sel=%0d busy=%b rst=%b, want 1 20 1 0 1 20 1 1",
                 i, rif.res_valid_o, rif.res_idx_o, rif.res_detected_o, rif.res_cycle_o,
                 rif.res_ch_o, mutsel_o, busy_o, dut_rst_o);
      end
      tick();
    end
    rif.res_ready_i = 1'b1; tick(); rif.res_ready_i = 1'b0;
    n_cmp++;
    if (rif.res_valid_o !== 1'b0 || mutsel_o !== 8'd21 || dut_rst_o !== 1'b1 ||
        busy_o !== 1'b1 || detected_cnt_o !== 9'd1) begin
      n_fail++;
      $display("FAIL stall_release: got v=%b sel=%0d rst=%b busy=%b cnt=%0d, want 0 21 1 1 1",
               rif.res_valid_o, mutsel_o, dut_rst_o, busy_o, detected_cnt_o);
    end
    rif.res_ready_i = 1'b1;
    for (int i = 0; i < 100 && !done_o; i++) tick();
    rif.res_ready_i = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || detected_cnt_o !== 9'd2) begin
      n_fail++;
      $display("FAIL stall_done: got done=%b cnt=%0d, want 1 2", done_o, detected_cnt_o);
    end
  endtask

  task automatic test_top_range();
    int nres, bad;
    logic [7:0] got_idx [2];
    golden_i = 16'hA55A; mutant_i = 16'h5AA5; sample_valid_i = 1'b1; rif.res_ready_i = 1'b1;
    start_sweep(8'd254, 8'd255, 16'd5, 2'b11);
    nres = 0; bad = 0;
    for (int t = 0; t < 100 && !done_o; t++) begin
      tick();
      if (rif.res_valid_o) begin
        if (nres < 2) got_idx[nres] = rif.res_idx_o;
        if (rif.res_detected_o !== 1'b1 || rif.res_cycle_o !== 16'd0) bad++;
        nres++;
      end
    end
    rif.res_ready_i = 1'b0;
    n_cmp++;
    if (nres != 2 || bad != 0 || got_idx[0] !== 8'd254 || got_idx[1] !== 8'd255) begin
      n_fail++;
      $display("FAIL top_results: got n=%0d bad=%0d idx0=%0d idx1=%0d, want 2 0 254 255",
               nres, bad, got_idx[0], got_idx[1]);
    end
    n_cmp++;
    if (done_o !== 1'b1 || detected_cnt_o !== 9'd2 || mutsel_o !== 8'd255 || busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL top_nowrap: got done=%b cnt=%0d sel=%0d busy=%b, want 1 2 255 0",
               done_o, detected_cnt_o, mutsel_o, busy_o);
    end
    start_sweep(8'd4, 8'd2, 16'd10, 2'b11);
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || rif.res_valid_o !== 1'b0 || detected_cnt_o !== 9'd0) begin
      n_fail++;
      $display("FAIL empty_range: got done=%b busy=%b v=%b cnt=%0d, want 1 0 0 0",
               done_o, busy_o, rif.res_valid_o, detected_cnt_o);
    end
    bad = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (rif.res_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL empty_range_idle: got %0d bad cycles, want 0", bad);
    end
  endtask

  task automatic test_mid_reset();
    bit ok1, ok2;
    golden_i = 16'hA55A; mutant_i = 16'hA55B; sample_valid_i = 1'b1; rif.res_ready_i = 1'b1;
    start_sweep(8'd1, 8'd3, 16'd20, 2'b11);
    wait_res(ok1);
    mutant_i = golden_i;
    tick();
    wait_rst_low(ok2);
    n_cmp++;
    if (!ok1 || !ok2 || detected_cnt_o !== 9'd1 || mutsel_o !== 8'd2) begin
      n_fail++;
      $display("FAIL midrst_pre: got res=%b run=%b cnt=%0d sel=%0d, want 1 1 1 2",
               ok1, ok2, detected_cnt_o, mutsel_o);
    end
    start_sweep(8'd100, 8'd100, 16'd3, 2'b01);
    n_cmp++;
    if (mutsel_o !== 8'd2 || busy_o !== 1'b1 || dut_rst_o !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored: got sel=%0d busy=%b rst=%b, want 2 1 0", mutsel_o, busy_o, dut_rst_o);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    rif.res_ready_i = 1'b0;
    n_cmp++;
    if (mutsel_o !== 8'd0 || busy_o !== 1'b0 || rif.res_valid_o !== 1'b0 || detected_cnt_o !== 9'd0 ||
        dut_rst_o !== 1'b1 || done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_post: got sel=%0d busy=%b v=%b cnt=%0d rst=%b done=%b, want 0 0 0 0 1 0",
               mutsel_o, busy_o, rif.res_valid_o, detected_cnt_o, dut_rst_o, done_o);
    end
  endtask

  initial begin
    rif.res_ready_i = 1'b0;
    test_reset();
    test_no_detect_sweep();
    test_early_exit();
    test_mask_and_valid();
    test_last_cycle();
    test_backpressure();
    test_top_range();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
